// File: rtl/key_debounce_pkg.sv
// key_debounce shared types and defaults.
// State encoding and 50 MHz timing constants.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } db_state_e;

    // 20 ms stability window at 50 MHz
    localparam int DEF_DEBOUNCE_COUNT = 1_000_000;
    // 1 s hold for a long press at 50 MHz
    localparam int DEF_LONG_COUNT     = 50_000_000;

    // Debounced level is high while the key is held or
    // while a release is still being qualified.
    function automatic logic is_down(input db_state_e s);
        return (s == PRESSED) || (s == RELEASE_CHK);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins.
// Reset value selectable so idle pins read inactive.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Shift the raw pin through two stages to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: sync, debounce both edges,
// press/release/long strobes and a wrapping press count.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = DEF_DEBOUNCE_COUNT,
    parameter int LONG_COUNT     = DEF_LONG_COUNT
) (
    input  logic       FPGA_CLK1_50,
    input  logic       rst,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       long_active,
    output logic [7:0] press_count
);

    localparam int CW = $clog2(DEBOUNCE_COUNT);
    localparam int HW = $clog2(LONG_COUNT + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_COUNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_COUNT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_COUNT);

    logic key_s;

    db_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          key_level_q, key_level_d;
    logic          press_pulse_q, press_pulse_d;
    logic          release_pulse_q, release_pulse_d;
    logic          long_pulse_q, long_pulse_d;
    logic          long_active_q, long_active_d;
    logic [7:0]    press_count_q, press_count_d;

    // Idle pin level is 1 (released), so reset the chain to 1
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (FPGA_CLK1_50),
        .rst_n (rst),
        .d     (key_n),
        .q     (key_s)
    );

    // Next-state logic: qualify each edge over a full stable window
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hcnt_d          = hcnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        long_active_d   = long_active_q;
        press_count_d   = press_count_q;

        unique case (state_q)
            RELEASED: begin
                if (!key_s) begin
                    state_d = PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (key_s) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                    hcnt_d        = '0;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                // Hold time saturates so the long strobe fires once
                if (hcnt_q != HOLD_MAX) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
                if (hcnt_q == HOLD_LAST && !long_active_q) begin
                    long_pulse_d  = 1'b1;
                    long_active_d = 1'b1;
                end
                if (key_s) begin
                    state_d = RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            RELEASE_CHK: begin
                // Hold counter is frozen here; a rejected
                // release bounce resumes it where it stopped
                if (!key_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = RELEASED;
                    release_pulse_d = 1'b1;
                    long_active_d   = 1'b0;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase

        key_level_d = is_down(state_d);
    end

    // State, counters and registered outputs
    always_ff @(posedge FPGA_CLK1_50 or negedge rst) begin
        if (!rst) begin
            state_q         <= RELEASED;
            cnt_q           <= '0;
            hcnt_q          <= '0;
            key_level_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            long_active_q   <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            hcnt_q          <= hcnt_d;
            key_level_q     <= key_level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            long_active_q   <= long_active_d;
            press_count_q   <= press_count_d;
        end
    end

    assign key_level     = key_level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign long_active   = long_active_q;
    assign press_count   = press_count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: strobe scoreboard keyed by
// cycle number plus direct level/count checks.
module tb_key_debounce;

    localparam int DB = 4;
    localparam int LG = 10;
    localparam int LAT = DB + 2;

    localparam logic [2:0] EV_PRESS = 3'b001;
    localparam logic [2:0] EV_REL   = 3'b010;
    localparam logic [2:0] EV_LONG  = 3'b100;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       long_active;
    logic [7:0] press_count;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t sb[$];

    key_debounce #(
        .DEBOUNCE_COUNT (DB),
        .LONG_COUNT     (LG)
    ) dut (
        .FPGA_CLK1_50  (clk),
        .rst           (rst),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_active   (long_active),
        .press_count   (press_count)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, obs, exp);
        end
    endtask

    // Strobes: every cycle with an observed or expected strobe
    // is compared against the events queued at stimulus time
    always @(negedge clk) begin : mon
        logic [2:0] obs;
        logic [2:0] ex;
        ev_t        e;
        obs = {long_pulse, release_pulse, press_pulse};
        ex  = '0;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc)
                check("missed_ev", 32'(e.cyc), 32'(cyc));
            else
                ex = ex | e.kind;
        end
        if (obs != 3'b0 || ex != 3'b0)
            check("strobes", 32'(obs), 32'(ex));
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push(input int c, input logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    task automatic check_outs(input string tag,
                              input logic lvl,
                              input logic la,
                              input logic [7:0] pc);
        check({tag, "_lvl"}, 32'(key_level), 32'(lvl));
        check({tag, "_la"}, 32'(long_active), 32'(la));
        check({tag, "_cnt"}, 32'(press_count), 32'(pc));
    endtask

    // Clean press held `hold` cycles past acceptance, then
    // clean release; both strobes queued with exact cycles
    task automatic press_release(input int hold);
        int e0;
        int e1;
        e0 = cyc + 1;
        key_n = 1'b0;
        push(e0 + LAT, EV_PRESS);
        wait_cyc(e0 + LAT + hold);
        e1 = cyc + 1;
        key_n = 1'b1;
        push(e1 + LAT, EV_REL);
        wait_cyc(e1 + LAT + 1);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: timeout at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int e0;
        int e1;

        // Reset held with the pin toggling
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            key_n = i[0];
            tick();
            check_outs("rst_hold", 1'b0, 1'b0, 8'd0);
        end
        key_n = 1'b1;
        rst = 1'b1;
        tick(10);
        check_outs("post_rst", 1'b0, 1'b0, 8'd0);

        // Clean press, held into long press
        e0 = cyc + 1;
        key_n = 1'b0;
        push(e0 + LAT, EV_PRESS);
        push(e0 + LAT + LG, EV_LONG);
        wait_cyc(e0 + LAT - 1);
        check("pre_accept_lvl", 32'(key_level), 32'd0);
        wait_cyc(e0 + LAT);
        check_outs("accept", 1'b1, 1'b0, 8'd1);
        wait_cyc(e0 + LAT + LG - 1);
        check("pre_long_la", 32'(long_active), 32'd0);
        wait_cyc(e0 + LAT + LG);
        check("long_la", 32'(long_active), 32'd1);
        tick(3);

        // Release bounce: two cycles high, then low again
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(8);
        check_outs("rel_bounce", 1'b1, 1'b1, 8'd1);

        // Clean release
        e1 = cyc + 1;
        key_n = 1'b1;
        push(e1 + LAT, EV_REL);
        wait_cyc(e1 + LAT - 1);
        check("pre_rel_lvl", 32'(key_level), 32'd1);
        wait_cyc(e1 + LAT);
        check_outs("release", 1'b0, 1'b0, 8'd1);
        tick(3);

        // Press bounce: low 3, high 2, low 2, high
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(2);
        key_n = 1'b0;
        tick(2);
        key_n = 1'b1;
        tick(10);
        check_outs("bounce", 1'b0, 1'b0, 8'd1);

        // Short press: no long strobe
        press_release(5);
        check_outs("short", 1'b0, 1'b0, 8'd2);

        // Reset while qualifying a press
        e0 = cyc + 1;
        key_n = 1'b0;
        wait_cyc(e0 + 3);
        rst = 1'b0;
        #1;
        check_outs("rst_chk", 1'b0, 1'b0, 8'd0);
        tick(2);
        key_n = 1'b1;
        tick();
        rst = 1'b1;
        tick(10);
        check_outs("rst_chk_after", 1'b0, 1'b0, 8'd0);

        // Key held low through reset deassertion
        rst = 1'b0;
        key_n = 1'b0;
        tick(2);
        rst = 1'b1;
        e0 = cyc + 1;
        push(e0 + LAT, EV_PRESS);
        wait_cyc(e0 + LAT);
        check_outs("held_rst", 1'b1, 1'b0, 8'd1);

        // Asynchronous reset mid-hold, checked before any edge
        tick(3);
        rst = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 1'b0, 8'd0);
        key_n = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(5);

        // Wrap of the press counter
        for (int i = 0; i < 255; i++) press_release(1);
        check_outs("cnt255", 1'b0, 1'b0, 8'd255);
        press_release(1);
        check_outs("wrap", 1'b0, 1'b0, 8'd0);

        tick(4);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
